// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters, one op in flight.
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention (default is round-robin).
package alu_arbiter_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_t;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  alu_op_t          req_op_0,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    output logic             rsp_valid_0,
    input  logic             rsp_ready_0,
    output logic [WIDTH-1:0] rsp_data_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  alu_op_t          req_op_1,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_data_1,
    output alu_op_t          alu_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   grant_id;
    logic   pick;
    logic   any_valid;
    logic   accept;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic   last_grant;
`endif

    assign any_valid = req_valid_0 | req_valid_1;

    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        pick = !req_valid_0;
`else
        if (req_valid_0 && req_valid_1)
            pick = !last_grant;
        else
            pick = !req_valid_0;
`endif
    end

    // rst_n gating keeps ready low while reset is held even though state reads IDLE
    assign accept      = rst_n && (state == IDLE) && any_valid;
    assign req_ready_0 = accept && !pick;
    assign req_ready_1 = accept && pick;
    assign rsp_valid_0 = (state == RESP) && !grant_id;
    assign rsp_valid_1 = (state == RESP) && grant_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
            alu_op     <= ALU_ADD;
            alu_in1    <= '0;
            alu_in2    <= '0;
            rsp_data_0 <= '0;
            rsp_data_1 <= '0;
        end else begin
            case (state)
                IDLE: if (any_valid) begin
                    grant_id <= pick;
                    alu_op   <= pick ? req_op_1 : req_op_0;
                    alu_in1  <= pick ? req_a_1  : req_a_0;
                    alu_in2  <= pick ? req_b_1  : req_b_0;
                    state    <= EXEC;
                end
                EXEC: begin
                    if (grant_id) rsp_data_1 <= alu_result;
                    else          rsp_data_0 <= alu_result;
                    state <= RESP;
                end
                RESP: if (grant_id ? rsp_ready_1 : rsp_ready_0) begin
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant <= grant_id;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
